// File: rtl/soc_system_ledr_pio.sv
// soc_system_ledr_pio: Avalon-MM output PIO driving LEDs/pins with a
// software level register plus self-timed per-bit pulses.
// Ports: clk, reset (async, active-high), address[2:0], chipselect,
//   write_n, writedata[31:0], readdata[31:0] (registered, latency 1),
//   out_port[WIDTH-1:0] = level | pulse_active, irq (level, active-high).
// Optional build macro: LEDR_PIO_DONE_IRQ_EN adds the irq mask (addr 2)
//   and done-capture (addr 3, write-1-to-clear) registers; without it
//   those addresses read 0, ignore writes, and irq is tied low.
// Map: 0 level, 1 pulse_len, 2 mask, 3 capture, 4 outset, 5 outclear,
//   6 trigger, 7 pulse_active status.
module soc_system_ledr_pio #(
  parameter int WIDTH         = 10,
  parameter int PULSE_W       = 16,
  parameter int RESET_VALUE   = 0,
  parameter int DEFAULT_PULSE = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0]   RST_LEVEL = WIDTH'(RESET_VALUE);
  localparam logic [PULSE_W-1:0] RST_PLEN  = PULSE_W'(DEFAULT_PULSE);
  localparam logic [PULSE_W-1:0] ONE       = PULSE_W'(1);

  localparam logic [2:0] A_LEVEL  = 3'd0;
  localparam logic [2:0] A_PLEN   = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_CAPT   = 3'd3;
  localparam logic [2:0] A_SET    = 3'd4;
  localparam logic [2:0] A_CLR    = 3'd5;
  localparam logic [2:0] A_TRIG   = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;

  logic               wr;
  logic [WIDTH-1:0]   wd;
  logic [PULSE_W-1:0] wd_plen;

  logic [WIDTH-1:0]   level;
  logic [PULSE_W-1:0] pulse_len;
  logic [PULSE_W-1:0] eff_len;
  logic [WIDTH-1:0]   pulse_active;
  logic [PULSE_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0]   trig;
  logic [WIDTH-1:0]   expire;
  logic [WIDTH-1:0]   done;

  logic [31:0]        rd_next;

  // Upper writedata bits are architecturally ignored.
  logic unused_bits;
  assign unused_bits = ^writedata;

  assign wr      = chipselect & ~write_n;
  assign wd      = writedata[WIDTH-1:0];
  assign wd_plen = writedata[PULSE_W-1:0];

  // A zero pulse length still yields a one-cycle pulse.
  assign eff_len = (pulse_len == '0) ? ONE : pulse_len;

  assign trig = (wr && address == A_TRIG) ? wd : '0;

  // A counter about to leave 1 ends its pulse; a retrigger on that
  // same edge reloads instead, so it is not a completion.
  always_comb begin
    expire = '0;
    for (int i = 0; i < WIDTH; i++) begin
      expire[i] = pulse_active[i] & (cnt[i] == ONE);
    end
  end

  assign done = expire & ~trig;

  assign out_port = level | pulse_active;

  // Level register with direct, set and clear write ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= RST_LEVEL;
    end else if (wr) begin
      case (address)
        A_LEVEL: level <= wd;
        A_SET:   level <= level | wd;
        A_CLR:   level <= level & ~wd;
        default: level <= level;
      endcase
    end
  end

  // Pulse length; only sampled at trigger time, so running
  // pulses keep the length they were started with.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_len <= RST_PLEN;
    end else if (wr && address == A_PLEN) begin
      pulse_len <= wd_plen;
    end
  end

  // Per-bit down-counters and active flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_active <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (trig[i]) begin
          cnt[i]          <= eff_len;
          pulse_active[i] <= 1'b1;
        end else if (pulse_active[i]) begin
          cnt[i] <= cnt[i] - ONE;
          if (expire[i]) begin
            pulse_active[i] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef LEDR_PIO_DONE_IRQ_EN
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] capt_clr;

  assign capt_clr = (wr && address == A_CAPT) ? wd : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
    end else if (wr && address == A_MASK) begin
      mask <= wd;
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture <= '0;
    end else begin
      capture <= (capture & ~capt_clr) | done;
    end
  end

  assign irq = |(capture & mask);
`else
  logic unused_done;
  assign unused_done = ^done;
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_next = '0;
    case (address)
      A_LEVEL:  rd_next = 32'(level);
      A_PLEN:   rd_next = 32'(pulse_len);
`ifdef LEDR_PIO_DONE_IRQ_EN
      A_MASK:   rd_next = 32'(mask);
      A_CAPT:   rd_next = 32'(capture);
`endif
      A_STATUS: rd_next = 32'(pulse_active);
      default:  rd_next = '0;
    endcase
  end

  // Registered read, independent of chipselect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_soc_system_ledr_pio.sv
// tb_soc_system_ledr_pio: self-checking bench for soc_system_ledr_pio.
// Reference model tracks each pulse as an absolute end time.
module tb_soc_system_ledr_pio;

  localparam int W = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0]  m_lvl;
  logic [15:0]   m_plen;
  logic [W-1:0]  m_msk;
  logic [W-1:0]  m_cap;
  int            m_end [W];
  int            now = 0;
  logic [31:0]   exp_rd;

  soc_system_ledr_pio dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] m_act();
    logic [W-1:0] a;
    a = '0;
    for (int i = 0; i < W; i++) a[i] = (m_end[i] > now);
    return a;
  endfunction

  function automatic logic [W-1:0] m_out();
    return m_lvl | m_act();
  endfunction

  function automatic logic m_irq();
    return |(m_cap & m_msk);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_lvl);
      3'd1:    return 32'(m_plen);
      3'd2:    return 32'(m_msk);
      3'd3:    return 32'(m_cap);
      3'd7:    return 32'(m_act());
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_lvl  = '0;
    m_plen = 16'd1000;
    m_msk  = '0;
    m_cap  = '0;
    for (int i = 0; i < W; i++) m_end[i] = now;
    exp_rd = '0;
  endtask

  task automatic setbus(input logic [2:0] a, input logic [31:0] d,
                        input logic w);
    address    = a;
    writedata  = d;
    chipselect = w;
    write_n    = ~w;
  endtask

  task automatic tick();
    logic         wr;
    logic [W-1:0] d;
    logic [W-1:0] done;
    int           len;
    @(posedge clk);
    exp_rd = m_read(address);
    wr   = chipselect && !write_n;
    d    = writedata[W-1:0];
    len  = (m_plen == 16'd0) ? 1 : int'(m_plen);
    now++;
    done = '0;
    for (int i = 0; i < W; i++) begin
      if (wr && address == 3'd6 && d[i]) m_end[i] = now + len;
      else if (m_end[i] == now) done[i] = 1'b1;
    end
    if (wr) begin
      case (address)
        3'd0: m_lvl  = d;
        3'd1: m_plen = writedata[15:0];
`ifdef LEDR_PIO_DONE_IRQ_EN
        3'd2: m_msk  = d;
`endif
        3'd4: m_lvl  = m_lvl | d;
        3'd5: m_lvl  = m_lvl & ~d;
        default: ;
      endcase
    end
`ifdef LEDR_PIO_DONE_IRQ_EN
    m_cap = (m_cap & ~((wr && address == 3'd3) ? d : '0)) | done;
`endif
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] want [3];
    logic [2:0]  addrs [3];
    want  = '{32'h000, 32'h3E8, 32'h000};
    addrs = '{3'd0, 3'd1, 3'd7};
    reset = 1'b1;
    setbus(3'd0, 32'd0, 1'b0);
    m_reset();
    #12;
    n_cmp++;
    if (out_port !== 10'h000 || readdata !== 32'd0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: out=%h rd=%h irq=%b want 000/0/0",
               out_port, readdata, irq);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      setbus(addrs[k], 32'd0, 1'b0);
      tick();
      n_cmp++;
      if (readdata !== want[k]) begin
        n_bad++;
        $display("FAIL reset_read a%0d: got %h want %h",
                 addrs[k], readdata, want[k]);
      end
    end
  endtask

  task automatic test_setclr();
    logic [2:0]  a [3];
    logic [31:0] d [3];
    logic [W-1:0] want [3];
    a    = '{3'd0, 3'd4, 3'd5};
    d    = '{32'h0F0, 32'h003, 32'h030};
    want = '{10'h0F0, 10'h0F3, 10'h0C3};
    for (int k = 0; k < 3; k++) begin
      setbus(a[k], d[k], 1'b1);
      tick();
      n_cmp++;
      if (out_port !== want[k]) begin
        n_bad++;
        $display("FAIL setclr%0d: got %h want %h", k, out_port, want[k]);
      end
    end
    setbus(3'd0, 32'd0, 1'b0);
    tick();
    n_cmp++;
    if (readdata !== 32'h0C3) begin
      n_bad++;
      $display("FAIL setclr_read: got %h want 0c3", readdata);
    end
  endtask

  task automatic test_pulse();
    int k;
    setbus(3'd0, 32'd0, 1'b1);
    tick();
    setbus(3'd1, 32'd5, 1'b1);
    tick();
    setbus(3'd6, 32'h001, 1'b1);
    tick();
    k = out_port[0] ? 1 : 0;
    setbus(3'd7, 32'd0, 1'b0);
    for (int j = 1; j < 50; j++) begin
      tick();
      if (j == 1) begin
        n_cmp++;
        if (readdata !== 32'h001) begin
          n_bad++;
          $display("FAIL pulse_status_on: got %h want 001", readdata);
        end
      end
      if (out_port[0]) k++;
      else break;
    end
    n_cmp++;
    if (k != 5) begin
      n_bad++;
      $display("FAIL pulse_len5: high %0d cycles want 5", k);
    end
    tick();
    n_cmp++;
    if (readdata !== 32'h000) begin
      n_bad++;
      $display("FAIL pulse_status_off: got %h want 000", readdata);
    end
  endtask

  task automatic test_retrigger(input int at, input int want);
    int k;
    setbus(3'd6, 32'h001, 1'b1);
    tick();
    k = out_port[0] ? 1 : 0;
    for (int j = 1; j < 50; j++) begin
      if (j == at) setbus(3'd6, 32'h001, 1'b1);
      else setbus(3'd0, 32'd0, 1'b0);
      tick();
      if (out_port[0]) k++;
      else break;
    end
    n_cmp++;
    if (k != want) begin
      n_bad++;
      $display("FAIL retrig_at%0d: high %0d cycles want %0d", at, k, want);
    end
  endtask

  task automatic test_irq();
`ifdef LEDR_PIO_DONE_IRQ_EN
    setbus(3'd3, 32'h3FF, 1'b1);
    tick();
    setbus(3'd2, 32'h002, 1'b1);
    tick();
    setbus(3'd1, 32'd3, 1'b1);
    tick();
    setbus(3'd6, 32'h002, 1'b1);
    tick();
    setbus(3'd3, 32'd0, 1'b0);
    tick();
    tick();
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_early: got %b want 0", irq);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_rise: got %b want 1", irq);
    end
    tick();
    n_cmp++;
    if (readdata !== 32'h002) begin
      n_bad++;
      $display("FAIL capt_read: got %h want 002", readdata);
    end
    setbus(3'd3, 32'h002, 1'b1);
    tick();
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_clear: got %b want 0", irq);
    end
    setbus(3'd6, 32'h001, 1'b1);
    tick();
    setbus(3'd3, 32'd0, 1'b0);
    repeat (4) tick();
    n_cmp++;
    if (readdata !== 32'h001 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL capt_unmasked: rd=%h irq=%b want 001/0",
               readdata, irq);
    end
`else
    setbus(3'd2, 32'h3FF, 1'b1);
    tick();
    setbus(3'd1, 32'd2, 1'b1);
    tick();
    setbus(3'd6, 32'h3FF, 1'b1);
    tick();
    setbus(3'd2, 32'd0, 1'b0);
    repeat (4) tick();
    n_cmp++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL mask_absent: rd=%h irq=%b want 0/0", readdata, irq);
    end
    setbus(3'd3, 32'd0, 1'b0);
    tick();
    n_cmp++;
    if (readdata !== 32'd0) begin
      n_bad++;
      $display("FAIL capt_absent: got %h want 0", readdata);
    end
`endif
  endtask

  task automatic test_reset_mid();
    setbus(3'd1, 32'd1000, 1'b1);
    tick();
    setbus(3'd6, 32'h200, 1'b1);
    tick();
    setbus(3'd7, 32'd0, 1'b0);
    repeat (10) tick();
    n_cmp++;
    if (out_port !== 10'h200 || readdata !== 32'h200) begin
      n_bad++;
      $display("FAIL mid_before: out=%h rd=%h want 200/200",
               out_port, readdata);
    end
    #2 reset = 1'b1;
    #1;
    m_reset();
    n_cmp++;
    if (out_port !== 10'h000 || readdata !== 32'd0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: out=%h rd=%h irq=%b want 0/0/0",
               out_port, readdata, irq);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) tick();
    n_cmp++;
    if (out_port !== 10'h000 || readdata !== 32'd0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_after: out=%h rd=%h irq=%b want 0/0/0",
               out_port, readdata, irq);
    end
`ifdef LEDR_PIO_DONE_IRQ_EN
    setbus(3'd3, 32'd0, 1'b0);
    repeat (2) tick();
    n_cmp++;
    if (readdata !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_capt: got %h want 0", readdata);
    end
`endif
  endtask

  task automatic test_random();
    logic [2:0]  a;
    logic [31:0] d;
    for (int n = 0; n < 400; n++) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd1) d = 32'($urandom_range(0, 12));
      address    = a;
      writedata  = d;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp++;
      if (out_port !== m_out()) begin
        n_bad++;
        $display("FAIL rand_out n%0d: got %h want %h", n, out_port, m_out());
      end
      n_cmp++;
      if (readdata !== exp_rd) begin
        n_bad++;
        $display("FAIL rand_rd n%0d: got %h want %h", n, readdata, exp_rd);
      end
      n_cmp++;
      if (irq !== m_irq()) begin
        n_bad++;
        $display("FAIL rand_irq n%0d: got %b want %b", n, irq, m_irq());
      end
    end
  endtask

  initial begin
    test_reset();
    test_setclr();
    test_pulse();
    test_retrigger(3, 8);
    test_retrigger(5, 10);
    test_irq();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
